// File: rtl/turn_move_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// turn_move_ctrl_pkg
// Shared game definitions: mode codes, player limits, the turn/move FSM state
// encoding and small helpers for player-count handling. Also imported by the
// per-player position counters that consume D / p_da.
// -----------------------------------------------------------------------------
package turn_move_ctrl_pkg;

    // Game mode codes carried on M.
    localparam logic [2:0] MODE_SETUP = 3'b010;
    localparam logic [2:0] MODE_PLAY  = 3'b011;

    // Player count limits; p_da is MAX_PLAYERS bits wide.
    localparam int unsigned MIN_PLAYERS = 2;
    localparam int unsigned MAX_PLAYERS = 4;

    // Turn/move FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MOVE = 2'd2
    } state_t;

    // Effective player count: the raw N is saturated into MIN..MAX players.
    function automatic logic [2:0] players_eff(input logic [2:0] n);
        logic [2:0] v;
        v = n;
        if (n < 3'(MIN_PLAYERS)) begin
            v = 3'(MIN_PLAYERS);
        end else if (n > 3'(MAX_PLAYERS)) begin
            v = 3'(MAX_PLAYERS);
        end
        return v;
    endfunction

    // Next player index, wrapping at the effective player count.
    function automatic logic [1:0] next_turn(input logic [1:0] t, input logic [2:0] n_eff);
        logic [2:0] inc;
        inc = {1'b0, t} + 3'd1;
        return (inc >= n_eff) ? 2'd0 : inc[1:0];
    endfunction

endpackage

// File: rtl/turn_move_ctrl_pacer.sv
// -----------------------------------------------------------------------------
// step_pacer
// Emits `count` single-cycle pulses, the first in the cycle right after load
// and the rest spaced STEP_GAP cycles apart.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset, clears both counters
//   load   in   capture `count` and restart pacing (first pulse next cycle)
//   count  in   number of pulses to emit (0 = nothing)
//   abort  in   clear both counters; wins over load
//   pulse  out  one-cycle pulse
//   done   out  high together with the final pulse of the sequence
// -----------------------------------------------------------------------------
module step_pacer #(
    parameter int STEP_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] count,
    input  logic       abort,
    output logic       pulse,
    output logic       done
);

    localparam int GW = $clog2(STEP_GAP + 1);
    // Gap counter reload: after a pulse it counts STEP_GAP-1 idle cycles down
    // to zero, so pulses land exactly STEP_GAP cycles apart.
    localparam logic [GW-1:0] GAP_RELOAD = GW'(STEP_GAP - 1);

    logic [2:0]    r_remaining;
    logic [GW-1:0] r_gap;

    // A pulse fires whenever steps remain and the gap has elapsed.
    assign pulse = (r_remaining != 3'd0) && (r_gap == '0);
    assign done  = pulse && (r_remaining == 3'd1);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_remaining <= 3'd0;
            r_gap       <= '0;
        end else if (load) begin
            r_remaining <= count;
            r_gap       <= '0;
        end else if (r_remaining != 3'd0) begin
            if (r_gap == '0) begin
                r_remaining <= r_remaining - 3'd1;
                // Last pulse leaves both counters at zero rather than parked
                // on the reload value.
                r_gap       <= done ? '0 : GAP_RELOAD;
            end else begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_move_ctrl.sv
// -----------------------------------------------------------------------------
// turn_move_ctrl
// Turn and move controller for a guessing board game. In PLAY the active
// player either guesses right (match: advance `steps` tiles, keep the turn)
// or wrong (miss: pass the turn to the next player). Tile advances are issued
// as paced one-cycle D pulses to the active player's position counter.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   M[2:0]       in   mode: SETUP / PLAY / anything else = idle
//   N[2:0]       in   player count, saturated to 2..4
//   match        in   one-cycle pulse, active player guessed right
//   miss         in   one-cycle pulse, active player guessed wrong
//   steps[2:0]   in   tiles to advance, sampled with match
//   D            out  one-cycle tile-advance pulse
//   p_da[3:0]    out  one-hot enable of the active player's counter
//   turn[1:0]    out  active player index
//   busy         out  move sequence in progress
//   o_dbg_state  out  current FSM state
//
// Guess events: match and miss are single-cycle pulses with no handshake.
// They are acted on only in WAIT with M == PLAY; anywhere else they are
// dropped, never queued. match takes priority over a simultaneous miss.
// -----------------------------------------------------------------------------
module turn_move_ctrl
    import turn_move_ctrl_pkg::*;
#(
    parameter int STEP_GAP  = 4,
    parameter int MAX_STEPS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] M,
    input  logic [2:0] N,
    input  logic       match,
    input  logic       miss,
    input  logic [2:0] steps,
    output logic       D,
    output logic [3:0] p_da,
    output logic [1:0] turn,
    output logic       busy,
    output state_t     o_dbg_state
);

    // Step clamp limit, saturated to what the 3-bit step counter can hold.
    localparam logic [2:0] MAX_STEPS_C = (MAX_STEPS > 7) ? 3'd7 : 3'(MAX_STEPS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_turn;

    logic       w_mode_play;
    logic       w_mode_setup;
    logic [2:0] w_n_eff;
    logic [2:0] w_steps_clamped;
    logic       w_load;
    logic       w_abort;
    logic       w_advance;
    logic       w_pace_pulse;
    logic       w_pace_done;

    assign w_mode_play     = (M == MODE_PLAY);
    assign w_mode_setup    = (M == MODE_SETUP);
    assign w_n_eff         = players_eff(N);
    assign w_steps_clamped = (steps > MAX_STEPS_C) ? MAX_STEPS_C : steps;

    step_pacer #(
        .STEP_GAP (STEP_GAP)
    ) u_pacer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .count (w_steps_clamped),
        .abort (w_abort),
        .pulse (w_pace_pulse),
        .done  (w_pace_done)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        w_advance   = 1'b0;
        if (!w_mode_play) begin
            // Leaving PLAY for any reason cancels a move in progress.
            w_state_nxt = ST_IDLE;
            w_abort     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (match) begin
                        // A zero-step match loads nothing useful and stays put.
                        w_load = 1'b1;
                        if (w_steps_clamped != 3'd0) begin
                            w_state_nxt = ST_MOVE;
                        end
                    end else if (miss) begin
                        w_advance = 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (w_pace_done) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Turn register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_mode_setup) begin
            r_turn <= 2'd0;
        end else if ({1'b0, r_turn} >= w_n_eff) begin
            // Player count shrank under the current turn.
            r_turn <= 2'd0;
        end else if (w_advance) begin
            r_turn <= next_turn(r_turn, w_n_eff);
        end
    end

    // D is additionally gated by the live mode so a pulse never escapes in
    // the cycle the mode drops out of PLAY.
    assign D           = w_pace_pulse && (r_state == ST_MOVE) && w_mode_play;
    assign busy        = (r_state == ST_MOVE);
    assign turn        = r_turn;
    assign p_da        = 4'b0001 << r_turn;
    assign o_dbg_state = r_state;

endmodule
